sram_bank_masked: RTL and testbench

// - Multi-way, byte-masked, synchronous-read SRAM bank for the L1 cache tag and data arrays.
// - Byte-write merging is done inside the bank, so stores and refills update only the bytes they own.
// - A built-in clear sequencer zeroes every entry after reset or on a flush request.
// - Sits directly under the cache FSM; one instance per array (tag or data), NUM_WAYS wide.

---
 rtl/sram_bank_masked_pkg.sv | 13 +
 rtl/sram_bank_masked_way.sv | 53 +++++
 rtl/sram_bank_masked.sv | 104 ++++++++++
 tb/tb_sram_bank_masked.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_bank_masked_pkg.sv
// Shared types and helpers for the masked SRAM bank and its ways.
package sram_bank_masked_pkg;

    typedef enum logic {
        SRAM_IDLE = 1'b0,
        SRAM_INIT = 1'b1
    } sram_state_e;

    function automatic int unsigned byte_count(input int unsigned width);
        return width / 8;
    endfunction

endpackage

// File: rtl/sram_bank_masked_way.sv
// One SRAM way: byte-masked write port, one-cycle read with write-first bypass.
module sram_bank_masked_way
    import sram_bank_masked_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_LEN   = 6,
    localparam int unsigned MASK_W    = byte_count(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_LEN-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [MASK_W-1:0]     wmask,
    input  logic                  ren,
    input  logic [ADDR_LEN-1:0]   raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_LEN;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] merged_c;

    // Write-first: bytes being written this cycle to the read index override the stored ones.
    always_comb begin
        merged_c = mem[raddr];
        for (int b = 0; b < int'(MASK_W); b++) begin
            if (we && wmask[b] && (waddr == raddr)) begin
                merged_c[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(MASK_W); b++) begin
                if (wmask[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (ren) begin
            rdata <= merged_c;
        end
    end

endmodule

// File: rtl/sram_bank_masked.sv
// Multi-way byte-masked SRAM bank with a clear sequencer for reset and flush.
module sram_bank_masked
    import sram_bank_masked_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_LEN      = 6,
    parameter int unsigned NUM_WAYS      = 2,
    parameter bit          INIT_ON_RESET = 1'b1,
    localparam int unsigned MASK_W       = byte_count(DATA_WIDTH)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush_req,
    output logic                           ready,
    output logic                           init_busy,
    input  logic                           ren,
    input  logic [ADDR_LEN-1:0]            raddr,
    input  logic [NUM_WAYS-1:0]            we,
    input  logic [ADDR_LEN-1:0]            waddr,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [MASK_W-1:0]              wmask,
    output logic [NUM_WAYS*DATA_WIDTH-1:0] rdata,
    output logic                           rvalid
);

    sram_state_e         state_q, state_d;
    logic [ADDR_LEN-1:0] init_cnt_q, init_cnt_d;

    logic [NUM_WAYS-1:0]   we_m;
    logic [ADDR_LEN-1:0]   waddr_m;
    logic [DATA_WIDTH-1:0] wdata_m;
    logic [MASK_W-1:0]     wmask_m;
    logic                  ren_m;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= INIT_ON_RESET ? SRAM_INIT : SRAM_IDLE;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // The counter wraps to zero in the same cycle the sweep hands back to IDLE.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        we_m       = we;
        waddr_m    = waddr;
        wdata_m    = wdata;
        wmask_m    = wmask;
        ren_m      = 1'b0;
        case (state_q)
            SRAM_IDLE: begin
                ren_m = ren;
                if (flush_req) begin
                    state_d    = SRAM_INIT;
                    init_cnt_d = '0;
                end
            end
            SRAM_INIT: begin
                we_m       = '1;
                waddr_m    = init_cnt_q;
                wdata_m    = '0;
                wmask_m    = '1;
                init_cnt_d = init_cnt_q + ADDR_LEN'(1);
                if (init_cnt_q == {ADDR_LEN{1'b1}}) begin
                    state_d = SRAM_IDLE;
                end
            end
            default: state_d = SRAM_IDLE;
        endcase
    end

    assign ready     = (state_q == SRAM_IDLE);
    assign init_busy = (state_q == SRAM_INIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid <= 1'b0;
        end else begin
            rvalid <= ren_m;
        end
    end

    for (genvar w = 0; w < int'(NUM_WAYS); w++) begin : g_way
        sram_bank_masked_way #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_LEN   (ADDR_LEN)
        ) u_way (
            .clk   (clk),
            .reset (reset),
            .we    (we_m[w]),
            .waddr (waddr_m),
            .wdata (wdata_m),
            .wmask (wmask_m),
            .ren   (ren_m),
            .raddr (raddr),
            .rdata (rdata[w*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_sram_bank_masked.sv
// Scoreboard bench for sram_bank_masked: reads push expected data, a monitor checks rvalid beats.
module tb_sram_bank_masked;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_req;
    logic        ready;
    logic        init_busy;
    logic        ren;
    logic [5:0]  raddr;
    logic [1:0]  we;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [63:0] rdata;
    logic        rvalid;

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q [$];

    sram_bank_masked #(
        .DATA_WIDTH    (32),
        .ADDR_LEN      (6),
        .NUM_WAYS      (2),
        .INIT_ON_RESET (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush_req (flush_req),
        .ready     (ready),
        .init_busy (init_busy),
        .ren       (ren),
        .raddr     (raddr),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .wmask     (wmask),
        .rdata     (rdata),
        .rvalid    (rvalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rvalid beat must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rvalid: got rdata %h, expected no beat", rdata);
            end else begin
                check("read_data", rdata, exp_q.pop_front());
            end
        end
    end

    task automatic do_read(input logic [5:0] a, input logic [63:0] exp);
        ren   = 1'b1;
        raddr = a;
        exp_q.push_back(exp);
        @(negedge clk);
        ren = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] w, input logic [5:0] a,
                            input logic [31:0] d, input logic [3:0] m);
        we    = w;
        waddr = a;
        wdata = d;
        wmask = m;
        @(negedge clk);
        we = 2'b00;
    endtask

    task automatic do_rw(input logic [1:0] w, input logic [5:0] wa, input logic [31:0] d,
                         input logic [3:0] m, input logic [5:0] ra, input logic [63:0] exp);
        we    = w;
        waddr = wa;
        wdata = d;
        wmask = m;
        ren   = 1'b1;
        raddr = ra;
        exp_q.push_back(exp);
        @(negedge clk);
        we  = 2'b00;
        ren = 1'b0;
    endtask

    // Counts negedges with init_busy high, optionally hammering ren/we during the sweep.
    task automatic count_busy(output int n, input bit poke);
        n = 0;
        while (init_busy === 1'b1 && n < 200) begin
            n++;
            if (poke) begin
                ren   = 1'b1;
                raddr = 6'(n);
                we    = 2'b11;
                waddr = 6'(n + 7);
                wdata = 32'hFFFF_FFFF;
                wmask = 4'hF;
            end
            @(negedge clk);
        end
        ren = 1'b0;
        we  = 2'b00;
    endtask

    initial begin
        int n;
        logic [63:0] held;
        reset     = 1'b1;
        flush_req = 1'b0;
        ren       = 1'b0;
        raddr     = '0;
        we        = '0;
        waddr     = '0;
        wdata     = '0;
        wmask     = '0;
        repeat (3) @(negedge clk);
        check("reset_rvalid", 64'(rvalid), 64'd0);
        check("reset_rdata", rdata, 64'd0);
        check("reset_busy", 64'(init_busy), 64'd1);
        check("reset_ready", 64'(ready), 64'd0);
        reset = 1'b0;

        count_busy(n, 1'b0);
        check("init_busy_cycles", 64'(n), 64'd64);
        check("ready_after_init", 64'(ready), 64'd1);

        for (int i = 0; i < 64; i++) begin
            do_read(6'(i), 64'd0);
        end

        do_write(2'b01, 6'd5, 32'hDEAD_BEEF, 4'b1111);
        do_write(2'b01, 6'd5, 32'h0000_1234, 4'b0011);
        do_read(6'd5, {32'h0, 32'hDEAD_1234});

        do_write(2'b10, 6'd9, 32'h1122_3344, 4'b1111);
        do_write(2'b01, 6'd9, 32'hCAFE_F00D, 4'b1111);
        do_rw(2'b10, 6'd9, 32'hA5A5_A5A5, 4'b0100, 6'd9, {32'h11A5_3344, 32'hCAFE_F00D});
        do_read(6'd9, {32'h11A5_3344, 32'hCAFE_F00D});

        do_rw(2'b11, 6'd20, 32'h0BAD_CAFE, 4'b1111, 6'd5, {32'h0, 32'hDEAD_1234});
        do_read(6'd20, {32'h0BAD_CAFE, 32'h0BAD_CAFE});

        do_write(2'b11, 6'd63, 32'h8000_0001, 4'b1111);
        do_read(6'd63, {32'h8000_0001, 32'h8000_0001});

        do_write(2'b11, 6'd5, 32'hFFFF_FFFF, 4'b0000);
        held = {32'h0, 32'hDEAD_1234};
        do_read(6'd5, held);
        raddr = 6'd9;
        @(negedge clk);
        repeat (3) begin
            check("hold_rvalid", 64'(rvalid), 64'd0);
            check("hold_rdata", rdata, held);
            @(negedge clk);
        end

        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        check("flush_ready_drop", 64'(ready), 64'd0);
        count_busy(n, 1'b1);
        check("flush_busy_cycles", 64'(n), 64'd64);
        check("ready_after_flush", 64'(ready), 64'd1);
        do_read(6'd0, 64'd0);
        do_read(6'd5, 64'd0);
        do_read(6'd9, 64'd0);
        do_read(6'd20, 64'd0);
        do_read(6'd63, 64'd0);

        do_write(2'b11, 6'd3, 32'h1357_9BDF, 4'b1111);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        repeat (30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        count_busy(n, 1'b0);
        check("reset_mid_sweep_cycles", 64'(n), 64'd64);
        do_read(6'd3, 64'd0);
        do_read(6'd63, 64'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
